dds_rom_sched: RTL

- Dual-channel DDS sequencer that time-shares one synchronous 256x8 waveform ROM (sin or saw table, 1-cycle read latency) between channels A and B.
- Owns both phase accumulators and issues ROM addresses in alternating slots.
- Realigns ROM data per channel and applies per-channel wave shaping.
- Takes configuration through a valid/ready write port; configuration changes take effect only at frame boundaries.

---
 rtl/dds_pkg.sv | 36 +++
 rtl/dds_phase_ch.sv | 82 ++++++++
 rtl/dds_rom_sched.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared encodings and reset defaults for the dual-channel DDS sequencer
package dds_pkg;

    typedef enum logic [1:0] {
        SEL_FTW  = 2'd0,
        SEL_POW  = 2'd1,
        SEL_MODE = 2'd2,
        SEL_AMP  = 2'd3
    } cfg_sel_e;

    typedef enum logic [1:0] {
        WAVE_ROM = 2'd0,
        WAVE_INV = 2'd1,
        WAVE_SQR = 2'd2,
        WAVE_OFF = 2'd3
    } wave_e;

    typedef enum logic {
        SLOT_A = 1'b0,
        SLOT_B = 1'b1
    } slot_e;

    typedef enum logic [1:0] {
        CFG_IDLE  = 2'd0,
        CFG_PEND  = 2'd1,
        CFG_DRAIN = 2'd2
    } cfg_state_e;

    localparam int MODE_CLR_BIT = 3;
    localparam int MODE_EN_BIT  = 2;

    // ROM wave, accumulator enabled, no clear request
    localparam logic [3:0] MODE_RST = 4'b0100;
    localparam logic [7:0] AMP_RST  = 8'hFF;

endpackage

// File: rtl/dds_phase_ch.sv
// rtl/dds_phase_ch.sv - one DDS channel: shadow/active config, phase accumulator, ROM address
module dds_phase_ch
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [1:0]             wr_sel,
    input  logic [PHASE_WIDTH-1:0] wr_data,
    input  logic                   step,
    input  logic                   apply,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic [1:0]             wave,
    output logic [7:0]             amp
);

    logic [PHASE_WIDTH-1:0] sh_ftw;
    logic [PHASE_WIDTH-1:0] sh_pow;
    logic [3:0]             sh_mode;
    logic [7:0]             sh_amp;
    logic [PHASE_WIDTH-1:0] ftw;
    logic [PHASE_WIDTH-1:0] pow;
    logic [2:0]             mode;
    logic [7:0]             amp_act;
    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] phase;

    // Shadow registers take writes; the clear request is consumed by the commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_ftw  <= '0;
            sh_pow  <= '0;
            sh_mode <= MODE_RST;
            sh_amp  <= AMP_RST;
        end else begin
            if (apply) begin
                sh_mode[MODE_CLR_BIT] <= 1'b0;
            end
            if (wr_en) begin
                case (cfg_sel_e'(wr_sel))
                    SEL_FTW:  sh_ftw  <= wr_data;
                    SEL_POW:  sh_pow  <= wr_data;
                    SEL_MODE: sh_mode <= wr_data[3:0];
                    SEL_AMP:  sh_amp  <= wr_data[7:0];
                    default:  sh_amp  <= sh_amp;
                endcase
            end
        end
    end

    // Frame-end update: accumulator advances with the outgoing config, then the commit lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            ftw     <= '0;
            pow     <= '0;
            mode    <= MODE_RST[2:0];
            amp_act <= AMP_RST;
        end else if (step) begin
            if (apply && sh_mode[MODE_CLR_BIT]) begin
                acc <= '0;
            end else if (mode[MODE_EN_BIT]) begin
                acc <= acc + ftw;
            end
            if (apply) begin
                ftw     <= sh_ftw;
                pow     <= sh_pow;
                mode    <= sh_mode[2:0];
                amp_act <= sh_amp;
            end
        end
    end

    assign phase = acc + pow;
    assign addr  = phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
    assign wave  = mode[1:0];
    assign amp   = amp_act;

endmodule

// File: rtl/dds_rom_sched.sv
// rtl/dds_rom_sched.sv - two-channel DDS sharing one ROM; DDS_AMP_SCALE_EN enables amplitude scaling
module dds_rom_sched
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   cfg_ch,
    input  logic [1:0]             cfg_sel,
    input  logic [PHASE_WIDTH-1:0] cfg_data,
    input  logic                   cfg_commit,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_q,
    output logic                   slot,
    output logic [DATA_WIDTH-1:0]  dout_a,
    output logic [DATA_WIDTH-1:0]  dout_b,
    output logic                   dout_valid
);

    slot_e                  slot_q;
    cfg_state_e             cfg_state;
    cfg_state_e             cfg_state_d;
    logic                   commit_apply;
    logic                   step;
    logic                   wr_a;
    logic                   wr_b;
    logic [ADDR_WIDTH-1:0]  addr_a;
    logic [ADDR_WIDTH-1:0]  addr_b;
    logic [1:0]             wave_a;
    logic [1:0]             wave_b;
    logic [7:0]             amp_a;
    logic [7:0]             amp_b;
    wave_e                  tag_wave;
    logic                   tag_msb;
    logic [DATA_WIDTH-1:0]  shaped;
    logic [DATA_WIDTH-1:0]  sample;
    logic                   primed;

    assign slot = slot_q;
    assign step = (slot_q == SLOT_B);
    assign wr_a = cfg_valid && cfg_ready && !cfg_ch;
    assign wr_b = cfg_valid && cfg_ready && cfg_ch;

    dds_phase_ch #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_ch_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_a),
        .wr_sel  (cfg_sel),
        .wr_data (cfg_data),
        .step    (step),
        .apply   (commit_apply),
        .addr    (addr_a),
        .wave    (wave_a),
        .amp     (amp_a)
    );

    dds_phase_ch #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_ch_b (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_b),
        .wr_sel  (cfg_sel),
        .wr_data (cfg_data),
        .step    (step),
        .apply   (commit_apply),
        .addr    (addr_b),
        .wave    (wave_b),
        .amp     (amp_b)
    );

    // Slot alternates every cycle: A issues in slot 0, B in slot 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= SLOT_A;
        end else begin
            slot_q <= (slot_q == SLOT_A) ? SLOT_B : SLOT_A;
        end
    end

    assign rom_addr = (slot_q == SLOT_A) ? addr_a : addr_b;

    // Commit handshake state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_state <= CFG_IDLE;
        end else begin
            cfg_state <= cfg_state_d;
        end
    end

    // Commit waits for the frame end, then holds ready low one more cycle
    always_comb begin
        cfg_state_d  = cfg_state;
        cfg_ready    = 1'b0;
        commit_apply = 1'b0;
        case (cfg_state)
            CFG_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_commit) begin
                    cfg_state_d = CFG_PEND;
                end
            end
            CFG_PEND: begin
                if (slot_q == SLOT_B) begin
                    commit_apply = 1'b1;
                    cfg_state_d  = CFG_DRAIN;
                end
            end
            CFG_DRAIN: cfg_state_d = CFG_IDLE;
            default:   cfg_state_d = CFG_IDLE;
        endcase
    end

`ifdef DDS_AMP_SCALE_EN
    logic [7:0]            tag_amp;
    logic [8:0]            amp_p1;
    logic [DATA_WIDTH+7:0] prod;

    // Amplitude travels with the issued address so it matches the returning word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_amp <= AMP_RST;
        end else begin
            tag_amp <= (slot_q == SLOT_A) ? amp_a : amp_b;
        end
    end

    assign amp_p1 = {1'b0, tag_amp} + 9'd1;
    assign prod   = {8'b0, shaped} * {{(DATA_WIDTH-1){1'b0}}, amp_p1};
    assign sample = DATA_WIDTH'(prod >> 8);
`else
    logic unused_amp;
    assign unused_amp = ^{amp_a, amp_b};
    assign sample     = shaped;
`endif

    // Wave mode and phase MSB travel with the issued address to line up with rom_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wave <= WAVE_ROM;
            tag_msb  <= 1'b0;
        end else begin
            tag_wave <= wave_e'((slot_q == SLOT_A) ? wave_a : wave_b);
            tag_msb  <= rom_addr[ADDR_WIDTH-1];
        end
    end

    // Per-channel wave shaping of the returning ROM word
    always_comb begin
        shaped = '0;
        case (tag_wave)
            WAVE_ROM: shaped = rom_q;
            WAVE_INV: shaped = ~rom_q;
            WAVE_SQR: shaped = {DATA_WIDTH{tag_msb}};
            default:  shaped = '0;
        endcase
    end

    // Output alignment: A lands at end of slot 1, B at end of slot 0, then a valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_a     <= '0;
            dout_b     <= '0;
            dout_valid <= 1'b0;
            primed     <= 1'b0;
        end else begin
            dout_valid <= (slot_q == SLOT_A) && primed;
            if (slot_q == SLOT_B) begin
                dout_a <= sample;
                primed <= 1'b1;
            end else if (primed) begin
                dout_b <= sample;
            end
        end
    end

endmodule
